// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO pointer/flag controller slice.
// Optional error reporting is enabled by defining FIFO_PTR_ERR_EN.
package fifo_pkg;

    // Default address width; depth is 2**BUFFER_WIDTH entries
    localparam int unsigned BUFFER_WIDTH   = 4;
    localparam int unsigned DEPTH          = 2 ** BUFFER_WIDTH;
    // Occupancy needs one extra bit to represent a completely full buffer
    localparam int unsigned CNT_W          = BUFFER_WIDTH + 1;
    // Default almost-full threshold (legal range 1..DEPTH)
    localparam int unsigned ALMOST_FULL_TH = 12;

endpackage

// File: rtl/fifo_ptr_inc.sv
// Wrapping pointer register with enable and synchronous active-low reset.
// The pointer naturally overflows from 2**W-1 back to 0.
module fifo_ptr_inc
    import fifo_pkg::*;
#(
    parameter int unsigned W = BUFFER_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] ptr
);

    // Advance the pointer by one on each enabled edge; clear on reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= ptr + W'(1);
        end
    end

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// FIFO pointer/flag controller: qualifies push/pop requests against
// Full/Empty, advances the write/read pointers, tracks occupancy and a
// registered almost-full flag. Full vs Empty on equal pointers is resolved
// by the Round bit returned from the downstream wrap-tracking stage.
// Define FIFO_PTR_ERR_EN to add sticky Overflow/Underflow outputs.
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned BufferWidth  = BUFFER_WIDTH,
    parameter int unsigned AlmostFullTh = ALMOST_FULL_TH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   Push_Req,
    input  logic                   Pop_Req,
    input  logic                   Round,
    output logic                   Push,
    output logic                   Pop,
    output logic [BufferWidth-1:0] W_Addr,
    output logic [BufferWidth-1:0] R_Addr,
    output logic                   Full,
    output logic                   Empty,
    output logic [BufferWidth:0]   Count,
    output logic                   Almost_Full
`ifdef FIFO_PTR_ERR_EN
    ,
    output logic                   Overflow,
    output logic                   Underflow
`endif
);

    localparam int unsigned CW = BufferWidth + 1;
    localparam logic [CW-1:0] AF_TH = CW'(AlmostFullTh);

    logic          same_addr;
    logic [CW-1:0] next_count;

    assign same_addr = (W_Addr == R_Addr);

    // Flags and request qualification; reset forces an empty, idle view
    always_comb begin
        Full  = 1'b0;
        Empty = 1'b1;
        Push  = 1'b0;
        Pop   = 1'b0;
        if (rst) begin
            Full  = same_addr & Round;
            Empty = same_addr & ~Round;
            Push  = Push_Req & ~Full;
            Pop   = Pop_Req & ~Empty;
        end
    end

    // Occupancy after this edge's accepted operations
    always_comb begin
        next_count = Count + CW'(Push) - CW'(Pop);
    end

    fifo_ptr_inc #(.W(BufferWidth)) u_w_ptr (
        .clk (clk),
        .rst (rst),
        .en  (Push),
        .ptr (W_Addr)
    );

    fifo_ptr_inc #(.W(BufferWidth)) u_r_ptr (
        .clk (clk),
        .rst (rst),
        .en  (Pop),
        .ptr (R_Addr)
    );

    // Register occupancy and the almost-full threshold flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            Count       <= '0;
            Almost_Full <= 1'b0;
        end else begin
            Count       <= next_count;
            Almost_Full <= (next_count >= AF_TH);
        end
    end

`ifdef FIFO_PTR_ERR_EN
    // Sticky error flags for requests made against a full/empty buffer
    always_ff @(posedge clk) begin
        if (!rst) begin
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            if (Push_Req && Full) begin
                Overflow <= 1'b1;
            end
            if (Pop_Req && Empty) begin
                Underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed testbench for fifo_ptr_ctrl (BufferWidth=4, AlmostFullTh=12).
// Includes a behavioural Round stage that toggles on each pointer wrap.
module tb_fifo_ptr_ctrl;

    logic       clk;
    logic       rst;
    logic       Push_Req;
    logic       Pop_Req;
    logic       Round;
    logic       Push;
    logic       Pop;
    logic [3:0] W_Addr;
    logic [3:0] R_Addr;
    logic       Full;
    logic       Empty;
    logic [4:0] Count;
    logic       Almost_Full;
`ifdef FIFO_PTR_ERR_EN
    logic       Overflow;
    logic       Underflow;
`endif

    int unsigned tests;
    int unsigned failed;

    fifo_ptr_ctrl #(.BufferWidth(4), .AlmostFullTh(12)) dut (
        .clk         (clk),
        .rst         (rst),
        .Push_Req    (Push_Req),
        .Pop_Req     (Pop_Req),
        .Round       (Round),
        .Push        (Push),
        .Pop         (Pop),
        .W_Addr      (W_Addr),
        .R_Addr      (R_Addr),
        .Full        (Full),
        .Empty       (Empty),
        .Count       (Count),
        .Almost_Full (Almost_Full)
`ifdef FIFO_PTR_ERR_EN
        ,
        .Overflow    (Overflow),
        .Underflow   (Underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Round stage: toggles when the write pointer wraps, toggles back when
    // the read pointer wraps; both wrapping together leaves it unchanged.
    always_ff @(posedge clk) begin
        if (!rst) begin
            Round <= 1'b0;
        end else begin
            Round <= Round ^ (Push && W_Addr == 4'hF) ^ (Pop && R_Addr == 4'hF);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, then let inputs/outputs settle
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        tests    = 0;
        failed   = 0;
        rst      = 1'b0;
        Push_Req = 1'b1;
        Pop_Req  = 1'b1;

        // 1. Reset with both requests asserted
        tick();
        tick();
        check("rst_push",  32'(Push), 0);
        check("rst_pop",   32'(Pop), 0);
        check("rst_empty", 32'(Empty), 1);
        check("rst_full",  32'(Full), 0);
        check("rst_waddr", 32'(W_Addr), 0);
        check("rst_raddr", 32'(R_Addr), 0);
        check("rst_count", 32'(Count), 0);
        check("rst_af",    32'(Almost_Full), 0);

        // 2. Fill 16 entries
        rst      = 1'b1;
        Pop_Req  = 1'b0;
        #2;
        for (int i = 0; i < 16; i++) begin
            check("fill_push",  32'(Push), 1);
            check("fill_count", 32'(Count), 32'(i));
            check("fill_waddr", 32'(W_Addr), 32'(i));
            check("fill_af",    32'(Almost_Full), (i >= 12) ? 1 : 0);
            tick();
        end
        check("full_flag",  32'(Full), 1);
        check("full_empty", 32'(Empty), 0);
        check("full_count", 32'(Count), 16);
        check("full_waddr", 32'(W_Addr), 0);
        check("full_af",    32'(Almost_Full), 1);
        check("full_push_rejected", 32'(Push), 0);
        tick();
        check("ovf_count", 32'(Count), 16);
        check("ovf_waddr", 32'(W_Addr), 0);
`ifdef FIFO_PTR_ERR_EN
        check("ovf_flag", 32'(Overflow), 1);
        check("ovf_unf_clear", 32'(Underflow), 0);
`endif

        // 3. Drain 16 entries
        Push_Req = 1'b0;
        Pop_Req  = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            check("drain_pop",   32'(Pop), 1);
            check("drain_count", 32'(Count), 32'(16 - i));
            check("drain_raddr", 32'(R_Addr), 32'(i));
            check("drain_af",    32'(Almost_Full), ((16 - i) >= 12) ? 1 : 0);
            tick();
        end
        check("empty_flag",  32'(Empty), 1);
        check("empty_full",  32'(Full), 0);
        check("empty_count", 32'(Count), 0);
        check("empty_raddr", 32'(R_Addr), 0);
        check("empty_af",    32'(Almost_Full), 0);
        check("empty_pop_rejected", 32'(Pop), 0);
        tick();
        check("unf_count", 32'(Count), 0);
        check("unf_raddr", 32'(R_Addr), 0);
`ifdef FIFO_PTR_ERR_EN
        check("unf_flag", 32'(Underflow), 1);
`endif

        // 4a. Empty with both requests: push only
        Push_Req = 1'b1;
        #1;
        check("emp_both_push", 32'(Push), 1);
        check("emp_both_pop",  32'(Pop), 0);
        tick();
        check("emp_both_count", 32'(Count), 1);
        check("emp_both_waddr", 32'(W_Addr), 1);
        check("emp_both_raddr", 32'(R_Addr), 0);

        // 4b. Refill to full, then both requests: pop only
        Pop_Req = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("refill_full",  32'(Full), 1);
        check("refill_count", 32'(Count), 16);
        Pop_Req = 1'b1;
        #1;
        check("full_both_push", 32'(Push), 0);
        check("full_both_pop",  32'(Pop), 1);
        tick();
        check("full_both_count", 32'(Count), 15);
        check("full_both_raddr", 32'(R_Addr), 1);
        check("full_both_waddr", 32'(W_Addr), 0);

        // 4c. Pop down to 5, then both accepted
        Push_Req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("mid_count", 32'(Count), 5);
        check("mid_af",    32'(Almost_Full), 0);
        Push_Req = 1'b1;
        #1;
        check("mid_both_push", 32'(Push), 1);
        check("mid_both_pop",  32'(Pop), 1);
        tick();
        check("mid_both_count", 32'(Count), 5);
        check("mid_both_waddr", 32'(W_Addr), 1);
        check("mid_both_raddr", 32'(R_Addr), 12);

        // 5. Steady concurrent traffic at Count=3 across pointer wraps
        Push_Req = 1'b0;
        tick();
        tick();
        check("steady_start_count", 32'(Count), 3);
        check("steady_start_raddr", 32'(R_Addr), 14);
        Push_Req = 1'b1;
        #1;
        for (int i = 0; i < 40; i++) begin
            check("steady_count", 32'(Count), 3);
            check("steady_full",  32'(Full), 0);
            check("steady_empty", 32'(Empty), 0);
            check("steady_both",  32'({Push, Pop}), 3);
            tick();
        end
        check("steady_waddr", 32'(W_Addr), 9);
        check("steady_raddr", 32'(R_Addr), 6);
        check("steady_end_count", 32'(Count), 3);

        // 6. Reset mid-operation at Count=9
        Pop_Req = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("pre_rst_count", 32'(Count), 9);
        rst = 1'b0;
        #1;
        check("mid_rst_push",  32'(Push), 0);
        check("mid_rst_empty", 32'(Empty), 1);
        check("mid_rst_full",  32'(Full), 0);
        tick();
        check("mid_rst_count", 32'(Count), 0);
        check("mid_rst_waddr", 32'(W_Addr), 0);
        check("mid_rst_raddr", 32'(R_Addr), 0);
`ifdef FIFO_PTR_ERR_EN
        check("mid_rst_ovf", 32'(Overflow), 0);
        check("mid_rst_unf", 32'(Underflow), 0);
`endif
        rst      = 1'b1;
        Push_Req = 1'b0;
        #1;
        check("post_rst_empty", 32'(Empty), 1);
        check("post_rst_count", 32'(Count), 0);
        check("post_rst_af",    32'(Almost_Full), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
